// File: rtl/imuldiv_mul_pkg.sv
// Shared encodings for the iterative imuldiv multiplier: FSM states,
// datapath operation selects and the counter width helper.
package imuldiv_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_NEXT = 1'b1
    } op_t;

    // Counter must hold W-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/imuldiv_mul_iter_param_dpath.sv
// Shift-add datapath: operand magnitude capture, partial-product accumulation,
// iteration counter and final sign correction of the product.
module imuldiv_mul_iter_param_dpath
    import imuldiv_mul_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  op_t            op_sel,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic [2*W-1:0] result,
    output logic           cnt_zero,
    output logic           b_hi_zero
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);

    logic [2*W-1:0] a_reg;
    logic [W-1:0]   b_reg;
    logic [2*W-1:0] res_reg;
    logic [CW-1:0]  cnt;
    logic           neg_reg;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;

    // The most-negative operand negates to itself, which read as unsigned is 2^(W-1).
    assign a_abs = (is_signed && a[W-1]) ? -a : a;
    assign b_abs = (is_signed && b[W-1]) ? -b : b;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            cnt     <= '0;
            neg_reg <= 1'b0;
        end else if (en) begin
            case (op_sel)
                OP_LOAD: begin
                    a_reg   <= {{W{1'b0}}, a_abs};
                    b_reg   <= b_abs;
                    res_reg <= '0;
                    cnt     <= CNT_INIT;
                    neg_reg <= is_signed && (a[W-1] ^ b[W-1]);
                end
                default: begin
                    if (b_reg[0]) begin
                        res_reg <= res_reg + a_reg;
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end
                end
            endcase
        end
    end

    assign cnt_zero  = (cnt == '0);
    assign b_hi_zero = (b_reg[W-1:1] == '0);
    assign result    = neg_reg ? -res_reg : res_reg;

endmodule

// File: rtl/imuldiv_mul_iter_param.sv
// Iterative signed/unsigned W x W -> 2W multiplier with val/rdy handshakes
// and optional early exit once the remaining multiplier bits are zero.
//   state   | meaning
//   ST_IDLE | waiting for a request, mulreq_rdy high
//   ST_CALC | one shift-add iteration per cycle
//   ST_DONE | product valid; may accept the next request as it is consumed
module imuldiv_mul_iter_param
    import imuldiv_mul_pkg::*;
#(
    parameter int W          = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [W-1:0]   mulreq_msg_a,
    input  logic [W-1:0]   mulreq_msg_b,
    input  logic           mulreq_msg_signed,
    input  logic           mulreq_val,
    output logic           mulreq_rdy,
    output logic [2*W-1:0] mulresp_msg_result,
    output logic           mulresp_val,
    input  logic           mulresp_rdy
);

    state_t state;
    logic   req_go;
    logic   resp_go;
    logic   calc_done;
    logic   cnt_zero;
    logic   b_hi_zero;
    logic   dp_en;
    op_t    dp_op;

    assign mulreq_rdy  = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && mulresp_rdy));
    assign mulresp_val = !reset && (state == ST_DONE);
    assign req_go      = mulreq_val && mulreq_rdy;
    assign resp_go     = mulresp_val && mulresp_rdy;
    assign calc_done   = cnt_zero || ((EARLY_EXIT != 0) && b_hi_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (req_go) state <= ST_CALC;
                ST_CALC: if (calc_done) state <= ST_DONE;
                ST_DONE: if (resp_go) state <= req_go ? ST_CALC : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign dp_en = req_go || (state == ST_CALC);
    assign dp_op = req_go ? OP_LOAD : OP_NEXT;

    imuldiv_mul_iter_param_dpath #(
        .W (W)
    ) u_dpath (
        .clk       (clk),
        .reset     (reset),
        .en        (dp_en),
        .op_sel    (dp_op),
        .a         (mulreq_msg_a),
        .b         (mulreq_msg_b),
        .is_signed (mulreq_msg_signed),
        .result    (mulresp_msg_result),
        .cnt_zero  (cnt_zero),
        .b_hi_zero (b_hi_zero)
    );

endmodule

// File: tb/tb_imuldiv_mul_iter_param.sv
// Bench for imuldiv_mul_iter_param: three builds (W=32 full-length, W=32 early-exit,
// W=8 early-exit) share one stimulus bus; expected products and latencies are queued.
module tb_imuldiv_mul_iter_param;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] a, b;
    logic        sgn;
    logic [2:0]  req_val;
    logic        resp_rdy;
    logic [2:0]  req_rdy, resp_val;
    logic [63:0] res0, res1;
    logic [15:0] res2;

    int          sel;
    logic        rdy_o, val_o;
    logic [63:0] res_o;

    always_comb begin
        rdy_o = req_rdy[0];
        val_o = resp_val[0];
        res_o = res0;
        case (sel)
            1: begin rdy_o = req_rdy[1]; val_o = resp_val[1]; res_o = res1; end
            2: begin rdy_o = req_rdy[2]; val_o = resp_val[2]; res_o = {48'b0, res2}; end
            default: ;
        endcase
    end

    imuldiv_mul_iter_param #(.W(32), .EARLY_EXIT(0)) d0 (
        .clk(clk), .reset(reset), .mulreq_msg_a(a), .mulreq_msg_b(b),
        .mulreq_msg_signed(sgn), .mulreq_val(req_val[0]), .mulreq_rdy(req_rdy[0]),
        .mulresp_msg_result(res0), .mulresp_val(resp_val[0]), .mulresp_rdy(resp_rdy));

    imuldiv_mul_iter_param #(.W(32), .EARLY_EXIT(1)) d1 (
        .clk(clk), .reset(reset), .mulreq_msg_a(a), .mulreq_msg_b(b),
        .mulreq_msg_signed(sgn), .mulreq_val(req_val[1]), .mulreq_rdy(req_rdy[1]),
        .mulresp_msg_result(res1), .mulresp_val(resp_val[1]), .mulresp_rdy(resp_rdy));

    imuldiv_mul_iter_param #(.W(8), .EARLY_EXIT(1)) d2 (
        .clk(clk), .reset(reset), .mulreq_msg_a(a[7:0]), .mulreq_msg_b(b[7:0]),
        .mulreq_msg_signed(sgn), .mulreq_val(req_val[2]), .mulreq_rdy(req_rdy[2]),
        .mulresp_msg_result(res2), .mulresp_val(resp_val[2]), .mulresp_rdy(resp_rdy));

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   ncmp = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 2) ? 8 : 32;
    endfunction

    function automatic logic [63:0] model(input logic [31:0] ai, input logic [31:0] bi,
                                          input logic si, input int w);
        logic [63:0] ea, eb;
        if (w == 32) begin
            ea = si ? {{32{ai[31]}}, ai} : {32'b0, ai};
            eb = si ? {{32{bi[31]}}, bi} : {32'b0, bi};
            return ea * eb;
        end
        ea = si ? {{56{ai[7]}}, ai[7:0]} : {56'b0, ai[7:0]};
        eb = si ? {{56{bi[7]}}, bi[7:0]} : {56'b0, bi[7:0]};
        return (ea * eb) & 64'hFFFF;
    endfunction

    function automatic int lat_of(input logic [31:0] bi, input logic si, input int s);
        int          w;
        int          k;
        logic [31:0] mask, ab;
        w = width_of(s);
        if (s == 0) return w;
        mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        ab = bi & mask;
        if (si && bi[w-1]) ab = (-bi) & mask;
        k = 1;
        for (int i = 0; i < w; i++) if (ab[i]) k = i + 1;
        return k;
    endfunction

    // Called at a negedge; returns #1 after the accepting posedge.
    task automatic send(input logic [31:0] ai, input logic [31:0] bi, input logic si);
        exp_t e;
        a = ai; b = bi; sgn = si;
        req_val[sel] = 1'b1;
        #1;
        check("req_rdy", 64'(rdy_o), 64'd1);
        e.res = model(ai, bi, si, width_of(sel));
        e.lat = lat_of(bi, si, sel);
        sb.push_back(e);
        @(posedge clk);
        #1 req_val = '0;
    endtask

    // Counts negedges from the first CALC cycle; leaves time at the first DONE negedge.
    task automatic recv(input string tag);
        exp_t e;
        int   n;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!val_o && n < 200);
        check({tag, "_lat"}, 64'(n), 64'(e.lat + 1));
        check({tag, "_res"}, res_o, e.res);
    endtask

    task automatic mul(input logic [31:0] ai, input logic [31:0] bi, input logic si, input string tag);
        @(negedge clk);
        send(ai, bi, si);
        recv(tag);
        @(posedge clk);
    endtask

    initial begin
        logic seen;
        reset = 1'b1; req_val = '1; resp_rdy = 1'b1;
        a = '0; b = '0; sgn = 1'b0; sel = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("rst_rdy", 64'(rdy_o), 64'd0);
            check("rst_val", 64'(val_o), 64'd0);
        end
        req_val = '0; reset = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("post_rdy", 64'(rdy_o), 64'd1);
            check("post_val", 64'(val_o), 64'd0);
            check("post_res", res_o, 64'd0);
        end

        sel = 0;
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max");
        mul(-32'sd3, 32'd5, 1'b1, "s_m3x5");
        mul(32'h8000_0000, 32'h8000_0000, 1'b1, "s_minxmin");
        mul(32'h8000_0000, 32'd1, 1'b1, "s_minx1");
        mul(32'd5, 32'hFFFF_FFFD, 1'b1, "s_5xm3");

        sel = 1;
        mul(32'd7, 32'd3, 1'b0, "ee_7x3");
        mul(32'h1234, 32'd0, 1'b0, "ee_bzero");
        mul(32'h8000_0000, 32'h8000_0000, 1'b1, "ee_minxmin");
        mul(32'd9, 32'hFFFF_FFFF, 1'b1, "ee_9xm1");
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            mul(ra, rb, i[0], "ee_rand");
        end

        // Backpressure on the full-length build, then back-to-back issue from DONE.
        sel = 0;
        resp_rdy = 1'b0;
        @(negedge clk);
        send(32'd9, 32'd11, 1'b0);
        recv("bp");
        a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_res", res_o, 64'd99);
            check("bp_rdy", 64'(rdy_o), 64'd0);
            check("bp_val", 64'(val_o), 64'd1);
        end
        resp_rdy = 1'b1;
        send(32'd6, 32'd7, 1'b0);
        recv("b2b");
        @(posedge clk);

        // Reset in the middle of CALC drops the in-flight product.
        @(negedge clk);
        send(32'd123, 32'd456, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (val_o) seen = 1'b1;
        end
        check("rst_mid_val", 64'(seen), 64'd0);
        sb.delete();
        mul(32'd2, 32'd2, 1'b0, "after_rst");

        sel = 2;
        mul(32'hFF, 32'hFF, 1'b0, "w8_u_max");
        mul(32'hFF, 32'hFF, 1'b1, "w8_s_m1xm1");
        mul(32'h80, 32'h7F, 1'b1, "w8_s_minxmax");
        mul(32'h0D, 32'h03, 1'b0, "w8_13x3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
